// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Initiator side of the Data_RAM port. Accepts byte-burst load/store requests
// from the control FSM, drives the RAM's single synchronous port and absorbs
// its one-cycle read latency. Store data streams in with a valid/ready
// handshake; load data streams out one byte per cycle with no backpressure.
//
// Build option:
//   MAU_WPROT_EN  When defined, store beats to addresses <= PROT_TOP are
//                 consumed but never reach the RAM, and the burst reports err
//                 with done. When undefined, err is constant 0 and every store
//                 beat is written.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store burst, 0 = load burst
//   addr_hi, addr_lo      start address {addr_hi, addr_lo}
//   req_len               burst length minus one (0 -> 1 byte, 255 -> 256)
//   wr_data/valid/ready   store data stream
//   rd_data, rd_valid     load data stream (registered, one beat per cycle)
//   done, err             end-of-burst pulse, write-protect flag valid with done
//   ram_we/addr/wdata     RAM request side
//   ram_rdata             RAM read data, valid the cycle after a read address
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 8,
  parameter logic [AW-1:0] PROT_TOP = 16'h00FF
) (
  input  logic          clk,
  input  logic          rst_n,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [7:0]    addr_hi,
  input  logic [7:0]    addr_lo,
  input  logic [7:0]    req_len,
  // store data stream
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  // load data stream
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  // completion
  output logic          done,
  output logic          err,
  // RAM port
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

`ifdef MAU_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e        state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;     // next RAM address of the burst
  logic [7:0]    cnt_q,     cnt_d;      // beats remaining minus one
  logic          rd_pipe_q, rd_pipe_d;  // address issued, RAM data due next cycle
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          done_q,    done_d;
  logic          err_acc_q, err_acc_d;  // sticky protect hit within the burst
  logic          err_q,     err_d;      // err as presented alongside done

  logic          prot_hit;
  logic          wr_beat;

  // Current store address falls inside the protected window. Constant 0 in the
  // default build, so the protect path folds away entirely.
  assign prot_hit = WPROT_EN && (addr_q <= PROT_TOP);
  assign wr_beat  = (state_q == ST_WRITE) && wr_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_acc_d  = err_acc_q;
    rd_pipe_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // Read pipeline second stage: RAM data for an address issued last cycle is
    // on ram_rdata now. rd_data keeps its value on idle cycles.
    rd_valid_d = rd_pipe_q;
    rd_data_d  = rd_pipe_q ? ram_rdata : rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = AW'({addr_hi, addr_lo});
          cnt_d     = req_len;
          err_acc_d = 1'b0;
          state_d   = req_write ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        // A stalled cycle (wr_valid=0) leaves address and count untouched.
        if (wr_valid) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - 8'd1;
          if (prot_hit) begin
            err_acc_d = 1'b1;
          end
          if (cnt_q == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            // Include the final beat's own protect hit.
            err_d   = err_acc_q | prot_hit;
          end
        end
      end

      ST_READ: begin
        rd_pipe_d = 1'b1;
        addr_d    = addr_q + AW'(1);
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The last byte is on rd_valid this cycle once the issue stage is
        // empty; done follows on the very next cycle.
        if (rd_valid_q && !rd_pipe_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = err_acc_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every register samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_acc_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_acc_q  <= err_acc_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The reset state is IDLE, so req_ready is qualified with rst_n to stay low
  // while reset is held.
  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_WRITE);

  // Write enable follows wr_valid combinationally so each beat is written in
  // the cycle it is handed over. Protected beats are consumed but suppressed.
  assign ram_we    = wr_beat && !prot_hit;
  assign ram_addr  = addr_q;
  assign ram_wdata = (state_q == ST_WRITE) ? wr_data : '0;

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A behavioural 64KB RAM sits on the
// RAM port; a separate expected-memory array, updated from the burst rules,
// predicts load data, RAM write traffic, latencies and err.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  addr_hi, addr_lo, req_len;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, done, err;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  typedef logic [7:0] bytes_t[$];

`ifdef MAU_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  bit   [7:0]  ram_mem [65536];   // contents of the RAM attached to the DUT
  bit   [7:0]  exp_mem [65536];   // what the RAM should hold
  logic [23:0] wlog[$];           // {addr, data} of every RAM write

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .addr_hi   (addr_hi),
    .addr_lo   (addr_lo),
    .req_len   (req_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      ram_mem[ram_addr] <= ram_wdata;
      wlog.push_back({ram_addr, ram_wdata});
    end
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_prot(input logic [15:0] a);
    return WP && (a <= 16'h00FF);
  endfunction

  // Random request traffic while a burst is running; it must be ignored.
  task automatic junk_req();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    addr_hi   = 8'($urandom);
    addr_lo   = 8'($urandom);
    req_len   = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ram_we"},    32'(ram_we),    32'd0);
    check({tag, ".ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, ".ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".wr_ready"},  32'(wr_ready),  32'd0);
    check({tag, ".rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, ".rd_data"},   32'(rd_data),   32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".err"},       32'(err),       32'd0);
  endtask

  // Store burst. Stalls are either random, or stall_cycles idle cycles
  // inserted once stall_after bytes have been handed over.
  task automatic do_store(input string tag, input logic [15:0] a, input bytes_t data,
                          input int stall_after, input int stall_cycles, input bit rnd_stall);
    int          n, idx, stalls, done_k, bad_ready, mism;
    logic        got_err;
    bit          exp_err, st;
    logic [15:0] ea;
    logic [23:0] exp_w[$];
    n = data.size(); idx = 0; stalls = 0; done_k = 0; bad_ready = 0; mism = 0;
    got_err = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      ea = a + 16'(i);
      if (is_prot(ea)) exp_err = 1'b1;
      else exp_w.push_back({ea, data[i]});
    end
    @(negedge clk);
    wlog.delete();
    req_valid = 1'b1; req_write = 1'b1;
    addr_hi = a[15:8]; addr_lo = a[7:0]; req_len = 8'(n - 1);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_k = k; got_err = err;
        break;
      end
      junk_req();
      if (idx < n) begin
        if (wr_ready !== 1'b1) bad_ready++;
        st = rnd_stall ? ($urandom_range(0, 2) == 0) : (idx == stall_after && stalls < stall_cycles);
        if (st) begin
          wr_valid = 1'b0; wr_data = 8'($urandom); stalls++;
        end else begin
          wr_valid = 1'b1; wr_data = data[idx]; idx++;
        end
      end else begin
        wr_valid = 1'b0;
      end
    end
    req_valid = 1'b0; wr_valid = 1'b0;
    check({tag, ".done_lat"}, 32'(done_k), 32'(n + stalls + 1));
    check({tag, ".err"}, 32'(got_err), 32'(exp_err));
    check({tag, ".wr_ready"}, 32'(bad_ready), 32'd0);
    check({tag, ".n_writes"}, 32'(wlog.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
      if (wlog[i] !== exp_w[i]) mism++;
    check({tag, ".write_trace"}, 32'(mism), 32'd0);
    for (int i = 0; i < n; i++) begin
      ea = a + 16'(i);
      if (!is_prot(ea)) exp_mem[ea] = data[i];
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Load burst of n bytes; expects rd_valid at cycles 3..n+2 after accept and
  // done at n+3.
  task automatic do_load(input string tag, input logic [15:0] a, input int n);
    int   first_k, last_k, done_k, ready_hi, mism;
    logic got_err;
    bytes_t got;
    first_k = 0; last_k = 0; done_k = 0; ready_hi = 0; mism = 0; got_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    addr_hi = a[15:8]; addr_lo = a[7:0]; req_len = 8'(n - 1);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        got.push_back(rd_data);
        if (first_k == 0) first_k = k;
        last_k = k;
      end
      if (req_ready !== 1'b0) ready_hi++;
      if (done === 1'b1) begin
        done_k = k; got_err = err;
        break;
      end
      junk_req();
    end
    req_valid = 1'b0;
    check({tag, ".first_rd"}, 32'(first_k), 32'd3);
    check({tag, ".n_beats"}, 32'(got.size()), 32'(n));
    check({tag, ".last_rd"}, 32'(last_k), 32'(n + 2));
    check({tag, ".done_lat"}, 32'(done_k), 32'(n + 3));
    check({tag, ".busy_ready"}, 32'(ready_hi), 32'd0);
    check({tag, ".err"}, 32'(got_err), 32'd0);
    for (int i = 0; i < n && i < got.size(); i++)
      if (got[i] !== exp_mem[16'(a + 16'(i))]) mism++;
    check({tag, ".data"}, 32'(mism), 32'd0);
    if (n == 1 && got.size() == 1) check({tag, ".byte0"}, 32'(got[0]), 32'(exp_mem[a]));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic reset_mid_burst();
    int bad_done, bad_rdy;
    bad_done = 0; bad_rdy = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    addr_hi = 8'h40; addr_lo = 8'h10; req_len = 8'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid.pre_rd_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done++;
      if (req_ready !== 1'b1) bad_rdy++;
    end
    check("rst_mid.no_done", 32'(bad_done), 32'd0);
    check("rst_mid.req_ready", 32'(bad_rdy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bytes_t      data;
    logic [15:0] a;
    int          n;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    addr_hi = 8'h00; addr_lo = 8'h00; req_len = 8'h00;
    wr_data = 8'hFF; wr_valid = 1'b1;   // busy inputs must not leak through reset
    #23;
    check_reset_outputs("por");
    wr_valid = 1'b0; wr_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("por.req_ready", 32'(req_ready), 32'd1);

    // Single byte store then load.
    data = '{8'hA5};
    do_store("single_st", 16'h1234, data, 0, 0, 1'b0);
    do_load("single_ld", 16'h1234, 1);

    // Four bytes with a two-cycle stall after the second byte.
    data = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_store("stall_st", 16'h0200, data, 2, 2, 1'b0);
    do_load("stall_ld", 16'h0200, 4);

    // Address wrap across FFFF.
    data = '{8'h5A, 8'hC3, 8'h7E};
    do_store("wrap_st", 16'hFFFE, data, 0, 0, 1'b0);
    do_load("wrap_ld", 16'hFFFE, 3);

    // Maximum burst length.
    do_load("max_ld", 16'h3F80, 256);

    // Protected window boundary (all writes land in the default build).
    data = '{8'hD1, 8'hD2};
    do_store("prot_st_00ff", 16'h00FF, data, 0, 0, 1'b0);
    do_store("prot_st_0100", 16'h0100, data, 0, 0, 1'b0);
    do_load("prot_ld", 16'h00FF, 2);

    reset_mid_burst();
    do_load("post_rst_ld", 16'h0200, 4);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       a = 16'($urandom);
        1:       a = 16'hFFF0 + 16'($urandom_range(0, 15));
        default: a = 16'h00F0 + 16'($urandom_range(0, 31));
      endcase
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 256)) : int'($urandom_range(1, 12));
      if ($urandom_range(0, 1) == 1) begin
        data.delete();
        for (int i = 0; i < n; i++) data.push_back(8'($urandom));
        do_store("rnd_st", a, data, 0, 0, 1'b1);
      end
      do_load("rnd_ld", a, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the Data_RAM port.
- Accepts byte-burst load/store requests from the control FSM, with the 16-bit address assembled from two 8-bit register-file outputs (addr_hi:addr_lo).
- Drives ram_we/ram_addr/ram_wdata and absorbs the RAM's one-cycle synchronous read latency.
- Streams write data in with a valid/ready handshake and streams read data out, one byte per cycle.

Parameters:
- AW, 16: RAM address width. Must be 16 (64KB byte space).
- DW, 8: data width. Must be 8.
- PROT_TOP, 16'h00FF: highest write-protected address. Used only with MAU_WPROT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  unit idle, request accepted on req_valid&&req_ready
- req_write  in  1  1=store burst, 0=load burst
- addr_hi  in  8  start address [15:8]
- addr_lo  in  8  start address [7:0]
- req_len  in  8  burst length minus 1 (0 = 1 byte, 255 = 256 bytes)
- wr_data  in  8  store data
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  unit consumes wr_data this cycle when wr_valid=1
- rd_data  out  8  load data (registered)
- rd_valid  out  1  rd_data valid, one cycle per byte, no backpressure
- done  out  1  one-cycle pulse at end of burst
- err  out  1  write-protect violation in finished burst, valid with done
- ram_we  out  1  to RAM write_enable
- ram_addr  out  16  to RAM address
- ram_wdata  out  8  to RAM data_in
- ram_rdata  in  8  from RAM data_out, valid the cycle after a non-write address is presented

Behaviour:
- Reset (async, rst_n=0) sets:
  - state IDLE
  - addr counter 0, beat counter 0
  - rd_data 0, rd_valid 0, done 0, err 0
  - read pipeline cleared
- Outputs during reset: ram_we=0, ram_addr=0, ram_wdata=0, req_ready=0, wr_ready=0.
- Reset mid-burst aborts the burst with no done pulse.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On accept: latch addr={addr_hi,addr_lo}, cnt=req_len, clear err.
  - Go to WRITE if req_write=1, else READ.
- WRITE:
  - wr_ready=1.
  - ram_we=wr_valid (combinational), ram_addr=addr, ram_wdata=wr_data.
  - Each beat (wr_valid=1): addr+=1, cnt-=1.
  - Beat with cnt==0 goes to DONE.
  - wr_valid=0 stalls: ram_we=0, addr holds. The resulting RAM read is harmless.
- READ:
  - ram_we=0, ram_addr=addr.
  - One address issued per cycle: addr+=1, cnt-=1.
  - Cycle issuing cnt==0 goes to DRAIN.
  - Issue in cycle k gives rd_data captured from ram_rdata, with rd_valid=1 in cycle k+2. This uses a 2-stage valid pipeline.
- DRAIN:
  - ram_we=0; no new addresses.
  - Go to DONE in the same cycle the last rd_valid is asserted.
- DONE:
  - done=1 for one cycle; err presented.
  - Next state IDLE. req_ready=0 in DONE.
- Latency:
  - Load of N bytes: accept at T; rd_valid at T+3..T+N+2; done at T+N+3.
  - Store of N bytes, no stalls: writes at T+1..T+N; done at T+N+1.
- Address wrap: 16'hFFFF+1 → 16'h0000 within a burst, no error.
- req_valid outside IDLE is ignored (not queued).
- rd_data holds its last value when rd_valid=0.

Optional Feature:
- Macro: MAU_WPROT_EN.
- Defined:
  - A store beat with addr<=PROT_TOP is consumed (wr_ready handshake, addr/cnt advance) but ram_we is forced to 0.
  - err is set sticky for the burst and presented at done.
- Undefined:
  - err is tied 0 and all stores reach the RAM.
  - PROT_TOP is unused.

Test Plan:
- Single store then load: store len=0, addr 12:34, data A5 → ram_we=1 one cycle at 16'h1234, done at T+2. Load len=0 → rd_valid at T+3 with A5, done at T+4.
- Burst store 4 bytes 11,22,33,44 at 16'h0200 with wr_valid low for 2 cycles after byte 2 → exactly 4 RAM writes to 0200..0203, done 2 cycles later than the unstalled case. Burst load → 4 consecutive rd_valid 11,22,33,44.
- Wrap: store 3 bytes at 16'hFFFE → writes to FFFE, FFFF, 0000. Load back matches.
- Max burst len=255: load → exactly 256 rd_valid beats, done once, req_ready low throughout.
- Reset mid-burst: assert rst_n=0 during a READ of len=7 → rd_valid, done and ram_we go 0 immediately. After release, req_ready=1 and no done pulse from the aborted burst.
- MAU_WPROT_EN, PROT_TOP=00FF: store 2 bytes at 00FF → RAM write only at 0100, err=1 with done. Same burst at 0100 → err=0.
